// File: rtl/mrv1_mem_arb_pkg.sv
// Shared types for the imem/dmem memory arbiter: request source IDs and counter width.
package mrv1_mem_arb_pkg;

   typedef enum logic {
      ARB_SRC_IMEM = 1'b0,
      ARB_SRC_DMEM = 1'b1
   } arb_src_e;

   localparam int unsigned ARB_STAT_W = 32;

   function automatic arb_src_e arb_other(input arb_src_e src);
      return (src == ARB_SRC_IMEM) ? ARB_SRC_DMEM : ARB_SRC_IMEM;
   endfunction

endpackage

// File: rtl/mrv1_mem_arb_route_fifo.sv
// Source-ID FIFO remembering which requester owns each outstanding memory response.
module mrv1_mem_arb_route_fifo
   import mrv1_mem_arb_pkg::*;
#(
   parameter int unsigned DEPTH_P = 2
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push_i,
   input  arb_src_e push_src_i,
   input  logic     pop_i,
   output logic     full_o,
   output logic     empty_o,
   output arb_src_e head_o
);

   localparam int unsigned      PTR_W    = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
   localparam int unsigned      CNT_W    = $clog2(DEPTH_P + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH_P - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH_P);

   arb_src_e         mem_q [DEPTH_P];
   arb_src_e         mem_d [DEPTH_P];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   // Push is refused at full even alongside a pop: there is no full-bypass path
   always_comb begin
      do_push  = push_i && (cnt_q != CNT_FULL);
      do_pop   = pop_i && (cnt_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_src_i;
         wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q    <= '{default: ARB_SRC_IMEM};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign full_o  = (cnt_q == CNT_FULL);
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mrv1_mem_arbiter.sv
// Round-robin arbiter sharing one TCM port between imem and dmem, with in-order response routing.
// Define MRV1_MEM_ARB_STATS_EN to build the accepted-request and stall performance counters.
module mrv1_mem_arbiter
   import mrv1_mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH_P = 32,
   parameter int unsigned DATA_WIDTH_P = 32,
   parameter int unsigned MAX_OUTST_P  = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        imem_req_vld_i,
   output logic                        imem_req_rdy_o,
   input  logic [ADDR_WIDTH_P-1:0]     imem_req_addr_i,
   output logic                        imem_resp_vld_o,
   output logic [DATA_WIDTH_P-1:0]     imem_resp_data_o,
   input  logic                        dmem_req_vld_i,
   output logic                        dmem_req_rdy_o,
   input  logic [ADDR_WIDTH_P-1:0]     dmem_req_addr_i,
   input  logic                        dmem_req_w_en_i,
   input  logic [DATA_WIDTH_P/8-1:0]   dmem_req_w_be_i,
   input  logic [DATA_WIDTH_P-1:0]     dmem_req_w_data_i,
   output logic                        dmem_resp_vld_o,
   output logic                        dmem_resp_err_o,
   output logic [DATA_WIDTH_P-1:0]     dmem_resp_r_data_o,
   output logic                        mem_req_vld_o,
   input  logic                        mem_req_rdy_i,
   output logic [ADDR_WIDTH_P-1:0]     mem_req_addr_o,
   output logic                        mem_req_w_en_o,
   output logic [DATA_WIDTH_P/8-1:0]   mem_req_w_be_o,
   output logic [DATA_WIDTH_P-1:0]     mem_req_w_data_o,
   input  logic                        mem_resp_vld_i,
   input  logic                        mem_resp_err_i,
   input  logic [DATA_WIDTH_P-1:0]     mem_resp_r_data_i,
   output logic [ARB_STAT_W-1:0]       stat_imem_cnt_o,
   output logic [ARB_STAT_W-1:0]       stat_dmem_cnt_o,
   output logic [ARB_STAT_W-1:0]       stat_stall_cnt_o
);

   arb_src_e last_grant_q, last_grant_d;
   arb_src_e grant_src;
   arb_src_e fifo_head;
   logic     fifo_full, fifo_empty;
   logic     mem_hs, resp_pop;

   // On conflict the source that did not win the last handshake goes next
   always_comb begin
      if (imem_req_vld_i && dmem_req_vld_i) begin
         grant_src = arb_other(last_grant_q);
      end else if (imem_req_vld_i) begin
         grant_src = ARB_SRC_IMEM;
      end else begin
         grant_src = ARB_SRC_DMEM;
      end
   end

   always_comb begin
      mem_req_vld_o    = (imem_req_vld_i | dmem_req_vld_i) & ~fifo_full & ~rst_i;
      mem_hs           = mem_req_vld_o & mem_req_rdy_i;
      imem_req_rdy_o   = (grant_src == ARB_SRC_IMEM) & mem_req_rdy_i & ~fifo_full & ~rst_i;
      dmem_req_rdy_o   = (grant_src == ARB_SRC_DMEM) & mem_req_rdy_i & ~fifo_full & ~rst_i;
      mem_req_addr_o   = imem_req_addr_i;
      mem_req_w_en_o   = 1'b0;
      mem_req_w_be_o   = '0;
      mem_req_w_data_o = '0;
      if (grant_src == ARB_SRC_DMEM) begin
         mem_req_addr_o   = dmem_req_addr_i;
         mem_req_w_en_o   = dmem_req_w_en_i;
         mem_req_w_be_o   = dmem_req_w_be_i;
         mem_req_w_data_o = dmem_req_w_data_i;
      end
      last_grant_d = mem_hs ? grant_src : last_grant_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_grant_q <= ARB_SRC_DMEM;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   mrv1_mem_arb_route_fifo #(
      .DEPTH_P (MAX_OUTST_P)
   ) u_route_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (mem_hs),
      .push_src_i (grant_src),
      .pop_i      (resp_pop),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .head_o     (fifo_head)
   );

   // Responses arriving with nothing outstanding are dropped without a pulse
   always_comb begin
      resp_pop           = mem_resp_vld_i & ~fifo_empty & ~rst_i;
      imem_resp_vld_o    = resp_pop & (fifo_head == ARB_SRC_IMEM);
      dmem_resp_vld_o    = resp_pop & (fifo_head == ARB_SRC_DMEM);
      imem_resp_data_o   = mem_resp_r_data_i;
      dmem_resp_r_data_o = mem_resp_r_data_i;
      dmem_resp_err_o    = mem_resp_err_i;
   end

`ifdef MRV1_MEM_ARB_STATS_EN
   logic [ARB_STAT_W-1:0] stat_imem_q, stat_imem_d;
   logic [ARB_STAT_W-1:0] stat_dmem_q, stat_dmem_d;
   logic [ARB_STAT_W-1:0] stat_stall_q, stat_stall_d;
   logic                  imem_stall, dmem_stall;

   // Stalls count per requester, so a blocked conflict adds two per cycle
   always_comb begin
      imem_stall   = imem_req_vld_i & ~imem_req_rdy_o;
      dmem_stall   = dmem_req_vld_i & ~dmem_req_rdy_o;
      stat_imem_d  = stat_imem_q + ARB_STAT_W'(imem_req_vld_i & imem_req_rdy_o);
      stat_dmem_d  = stat_dmem_q + ARB_STAT_W'(dmem_req_vld_i & dmem_req_rdy_o);
      stat_stall_d = stat_stall_q + ARB_STAT_W'(imem_stall) + ARB_STAT_W'(dmem_stall);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_imem_q  <= '0;
         stat_dmem_q  <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_imem_q  <= stat_imem_d;
         stat_dmem_q  <= stat_dmem_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_imem_cnt_o  = stat_imem_q;
   assign stat_dmem_cnt_o  = stat_dmem_q;
   assign stat_stall_cnt_o = stat_stall_q;
`else
   assign stat_imem_cnt_o  = '0;
   assign stat_dmem_cnt_o  = '0;
   assign stat_stall_cnt_o = '0;
`endif

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(mem_resp_vld_i && fifo_empty))
            else $warning("mrv1_mem_arbiter: response with no outstanding request dropped");
      end
   end
`endif

endmodule
